fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
Output reorder stage that sits directly downstream of the last fix_butterfly stage of the 256-point fixed-point FFT. It accepts complex results in bit-reversed index order, one per cycle, and buffers them in a ping-pong pair of banks. It emits each completed frame in natural index order with frame markers and a valid/ready handshake. Data are treated as raw WIDTH-bit fixed-point words (11 integer, 9 fractional bits by default) and pass through unmodified.

Parameters:
N, 256, FFT length (power of two, >= 4)
LOG2N, 8, log2(N); sets counter and address width
WIDTH, 20, width of each real/imag word; equals the butterfly WIDTHr

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  reset
en  input  1  input sample valid (same name and meaning as butterfly en/vld)
din_r  input  WIDTH  real part, bit-reversed order
din_i  input  WIDTH  imag part
in_ready  output  1  block can capture a sample this cycle
dout_r  output  WIDTH  real part, natural order
dout_i  output  WIDTH  imag part
vld_out  output  1  dout valid
out_ready  input  1  downstream accepts dout this cycle
sop  output  1  dout is index 0 of a frame
eop  output  1  dout is index N-1 of a frame
overflow  output  1  sticky: a sample was presented while in_ready=0

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. During reset and after release: vld_out=0, sop=0, eop=0, dout_r=dout_i=0, overflow=0, in_ready=1, both banks EMPTY, wsel=rsel=bank0, counters=0. Bank contents are not cleared.
- Capture: a sample is written when en & in_ready at a rising edge. Write address is bitrev_LOG2N(wcnt) in bank wsel, then wcnt increments.
- Write-side bank state: EMPTY -> FILLING on first capture. FILLING -> FULL on capture with wcnt=N-1. In the same edge, wcnt wraps to 0 and wsel toggles.
- in_ready = 1 iff bank wsel is EMPTY or FILLING. It is combinational from bank state.
- en while in_ready=0: sample is dropped, wcnt is unchanged, and overflow is set (sticky until rst).
- Read side: the reader drains bank rsel when it is FULL (state DRAINING) at addresses rcnt=0..N-1 ascending. The read is combinational from the register array, and the output is registered.
- Output handshake: the output register loads when (!vld_out | out_ready) and a sample is available. vld_out, dout_*, sop and eop hold while vld_out & !out_ready. rcnt advances only on load.
- sop=1 with rcnt=0 word, eop=1 with rcnt=N-1 word. After loading the eop word, the bank becomes EMPTY and rsel toggles, in the same edge.
- Latency: if the last sample of a frame is captured at edge t, and the output register is free, the first output (sop) is valid after edge t+1. With out_ready=1 and continuous en, the stream runs at 1 sample/cycle with no bubbles and in_ready stays 1.
- Simultaneous events: a bank freed by the reader at edge t is writable at t+1. The writer and reader never target the same bank. Completing a write and finishing a drain in the same edge are both honoured.
- Reset mid-frame: all partial input and output frames are discarded. The next capture is index 0.

Decomposition:
- Shared package fft_pkg:
  - N/LOG2N/WIDTH defaults, with WIDTH_I=11 and WIDTH_F=9
  - bank state encoding: EMPTY, FILLING, FULL, DRAINING
  - function bitrev(value, LOG2N)
- One sub-module, fft_bitrev_bank: N x 2*WIDTH register array with one synchronous write port and one combinational read port. It is instantiated twice.
- Top holds wcnt/rcnt, wsel/rsel, the two bank-state registers, the output register and the overflow flag.

Test Plan:
- Basic reorder, N=8: feed values 0,4,2,6,1,5,3,7 (real; imag = value+100) with en=1 and out_ready=1. Required output: 0..7 in order (imag 100..107), sop on 0, eop on 7, first vld_out one edge after the 8th capture.
- Back-to-back frames: two 8-sample frames with no gap. Required: 16 outputs with no bubble, in_ready constantly 1, sop/eop at output positions 0/7/8/15.
- Backpressure: out_ready=0 for 20 cycles while two frames are input. Required: in_ready drops after the 16th capture, and a 17th en sets overflow=1. dout is held stable at word 0, and after release the outputs are 0..7,0..7 with no loss.
- Reset mid-frame: assert rst after 5 captures, then feed a full frame. Required: all outputs go to 0 immediately, overflow=0, and only the new frame appears, in correct order.
- Random stall: random en and out_ready over 50 frames with random data. Required: output matches bitrev-scatter reference model, and overflow stays 0 when en respects in_ready.
- N=256 default: one frame of butterfly-format words, e.g. real = k<<9 at natural index k. Required: natural-order output, with sop at k=0 and eop at k=255.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 256-point fixed-point FFT datapath:
// default sizes, ping-pong bank state encoding and the index bit-reversal helper.
package fft_pkg;

    localparam int N_DEF      = 256;
    localparam int LOG2N_DEF  = 8;
    localparam int WIDTH_I    = 11;
    localparam int WIDTH_F    = 9;
    localparam int WIDTH_DEF  = WIDTH_I + WIDTH_F;
    localparam int BITREV_MAX = 16;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_e;

    // Reverses the low log2n bits of value; bits above log2n come back as zero.
    function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] value,
                                                    input int log2n);
        logic [BITREV_MAX-1:0] v;
        logic [BITREV_MAX-1:0] r;
        v = value;
        r = '0;
        for (int b = 0; b < BITREV_MAX; b++) begin
            if (b < log2n) begin
                r = {r[BITREV_MAX-2:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_bank.sv
// One half of the reorder ping-pong buffer: N words of packed {real, imag},
// written synchronously at a scattered address, read combinationally.
module fft_bitrev_bank
    import fft_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LOG2N = LOG2N_DEF,
    parameter int DW    = 2 * WIDTH_DEF
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [LOG2N-1:0] i_waddr,
    input  logic [DW-1:0]    i_wdata,
    input  logic [LOG2N-1:0] i_raddr,
    output logic [DW-1:0]    o_rdata
);

    logic [DW-1:0] r_mem [N];

    // NOTE: storage has no reset; the bank state flags decide which words are meaningful.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts bit-reversed FFT output into natural order through two ping-pong banks,
// emitting frames with sop/eop markers under a valid/ready handshake.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LOG2N = LOG2N_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din_r,
    input  logic [WIDTH-1:0] din_i,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout_r,
    output logic [WIDTH-1:0] dout_i,
    output logic             vld_out,
    input  logic             out_ready,
    output logic             sop,
    output logic             eop,
    output logic             overflow
);

    localparam int               DW   = 2 * WIDTH;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [LOG2N-1:0] r_wcnt;
    logic [LOG2N-1:0] r_rcnt;
    logic             r_wsel;
    logic             r_rsel;
    bank_state_e      r_state [2];
    logic             r_vld;
    logic             r_sop;
    logic             r_eop;
    logic             r_ovf;
    logic [WIDTH-1:0] r_dout_r;
    logic [WIDTH-1:0] r_dout_i;

    bank_state_e      w_state_nxt [2];
    bank_state_e      w_wstate;
    bank_state_e      w_rstate;
    logic             w_capture;
    logic             w_avail;
    logic             w_load;
    logic             w_wlast;
    logic             w_rlast;
    logic [1:0]       w_we;
    logic [LOG2N-1:0] w_waddr;
    logic [DW-1:0]    w_wdata;
    logic [DW-1:0]    w_rdata0;
    logic [DW-1:0]    w_rdata1;
    logic [DW-1:0]    w_rdata;

    assign w_wstate  = r_state[r_wsel];
    assign w_rstate  = r_state[r_rsel];
    assign in_ready  = (w_wstate == EMPTY) || (w_wstate == FILLING);
    assign w_capture = en && in_ready;
    assign w_avail   = (w_rstate == FULL) || (w_rstate == DRAINING);
    assign w_load    = w_avail && (!r_vld || out_ready);
    assign w_wlast   = (r_wcnt == LAST);
    assign w_rlast   = (r_rcnt == LAST);

    assign w_waddr = LOG2N'(bitrev(BITREV_MAX'(r_wcnt), LOG2N));
    assign w_wdata = {din_r, din_i};
    assign w_we    = {w_capture && r_wsel, w_capture && !r_wsel};
    assign w_rdata = r_rsel ? w_rdata1 : w_rdata0;

    fft_bitrev_bank #(.N(N), .LOG2N(LOG2N), .DW(DW)) u_bank0 (
        .clk     (clk),
        .i_we    (w_we[0]),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_rcnt),
        .o_rdata (w_rdata0)
    );

    fft_bitrev_bank #(.N(N), .LOG2N(LOG2N), .DW(DW)) u_bank1 (
        .clk     (clk),
        .i_we    (w_we[1]),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_rcnt),
        .o_rdata (w_rdata1)
    );

    // Writer and reader only ever own banks in disjoint states, so both updates can land together.
    // NOTE: every output is given its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt[0] = r_state[0];
        w_state_nxt[1] = r_state[1];
        if (w_capture) begin
            w_state_nxt[r_wsel] = w_wlast ? FULL : FILLING;
        end
        if (w_load) begin
            w_state_nxt[r_rsel] = w_rlast ? EMPTY : DRAINING;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state[0] <= EMPTY;
            r_state[1] <= EMPTY;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_wsel     <= 1'b0;
            r_rsel     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
            if (w_capture) begin
                r_wcnt <= r_wcnt + LOG2N'(1);
                if (w_wlast) begin
                    r_wsel <= !r_wsel;
                end
            end
            if (w_load) begin
                r_rcnt <= r_rcnt + LOG2N'(1);
                if (w_rlast) begin
                    r_rsel <= !r_rsel;
                end
            end
            if (en && !in_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= 1'b0;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_dout_r <= '0;
            r_dout_i <= '0;
        end else if (w_load) begin
            r_vld    <= 1'b1;
            r_sop    <= (r_rcnt == '0);
            r_eop    <= w_rlast;
            r_dout_r <= w_rdata[DW-1:WIDTH];
            r_dout_i <= w_rdata[WIDTH-1:0];
        end else if (out_ready) begin
            r_vld <= 1'b0;
            r_sop <= 1'b0;
            r_eop <= 1'b0;
        end
    end

    assign vld_out  = r_vld;
    assign sop      = r_sop;
    assign eop      = r_eop;
    assign dout_r   = r_dout_r;
    assign dout_i   = r_dout_i;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: an N=8 instance against a frame-level
// scatter model, plus an N=256 instance fed one butterfly-format frame.
module tb_fft_bitrev_reorder;

    localparam int W  = 20;
    localparam int NS = 8;
    localparam int NL = 256;

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [W-1:0] r;
        logic [W-1:0] i;
    } word_t;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         en        = 1'b0;
    logic [W-1:0] din_r     = '0;
    logic [W-1:0] din_i     = '0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         vld_out;
    logic         sop;
    logic         eop;
    logic         overflow;
    logic [W-1:0] dout_r;
    logic [W-1:0] dout_i;

    logic         en_l   = 1'b0;
    logic [W-1:0] din_lr = '0;
    logic [W-1:0] din_li = '0;
    logic         in_ready_l;
    logic         vld_l;
    logic         sop_l;
    logic         eop_l;
    logic         ovf_l;
    logic [W-1:0] dout_lr;
    logic [W-1:0] dout_li;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    word_t        exp_q [$];
    logic [2*W-1:0] m_frame [NS];
    int           m_pos     = 0;
    logic         m_ovf     = 1'b0;
    logic         prev_hold = 1'b0;
    word_t        prev_word;
    word_t        acc_log [512];
    int           acc_cyc [512];
    int           log_n     = 0;

    fft_bitrev_reorder #(.N(NS), .LOG2N(3), .WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .en(en), .din_r(din_r), .din_i(din_i),
        .in_ready(in_ready), .dout_r(dout_r), .dout_i(dout_i), .vld_out(vld_out),
        .out_ready(out_ready), .sop(sop), .eop(eop), .overflow(overflow)
    );

    fft_bitrev_reorder #(.N(NL), .LOG2N(8), .WIDTH(W)) u_dut_256 (
        .clk(clk), .rst(rst), .en(en_l), .din_r(din_lr), .din_i(din_li),
        .in_ready(in_ready_l), .dout_r(dout_lr), .dout_i(dout_li), .vld_out(vld_l),
        .out_ready(1'b1), .sop(sop_l), .eop(eop_l), .overflow(ovf_l)
    );

    always #5 clk = ~clk;

    function automatic int bitrev_tb(input int v, input int bits);
        int r;
        int x;
        r = 0;
        x = v;
        for (int b = 0; b < bits; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Compare process: checks the presented word against the model, then
    // applies the handshake events that the coming rising edge will perform.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("reset_state", {vld_out, sop, eop, overflow, in_ready, dout_r, dout_i},
                  {4'b0000, 1'b1, {(2*W){1'b0}}});
            exp_q.delete();
            m_pos     = 0;
            m_ovf     = 1'b0;
            prev_hold = 1'b0;
        end else begin
            check("overflow", overflow, m_ovf);
            if (vld_out) begin
                if (exp_q.size() == 0) begin
                    check("spurious_vld", vld_out, 1'b0);
                end else begin
                    check("dout", {sop, eop, dout_r, dout_i}, exp_q[0]);
                end
            end
            if (prev_hold) begin
                check("hold", {vld_out, sop, eop, dout_r, dout_i}, {1'b1, prev_word});
            end
            prev_hold = vld_out && !out_ready;
            prev_word = {sop, eop, dout_r, dout_i};
            if (vld_out && out_ready) begin
                if (log_n < 512) begin
                    acc_log[log_n] = {sop, eop, dout_r, dout_i};
                    acc_cyc[log_n] = cyc;
                end
                log_n++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (en && !in_ready) m_ovf = 1'b1;
            if (en && in_ready) begin
                m_frame[bitrev_tb(m_pos, 3)] = {din_r, din_i};
                m_pos++;
                if (m_pos == NS) begin
                    for (int k = 0; k < NS; k++) begin
                        exp_q.push_back({k == 0, k == NS - 1, m_frame[k]});
                    end
                    m_pos = 0;
                end
            end
        end
    end

    task automatic feed(input int base_r, input int base_i, input bit chk_rdy);
        for (int p = 0; p < NS; p++) begin
            int k;
            k = bitrev_tb(p, 3);
            if (chk_rdy) check("in_ready_high", in_ready, 1'b1);
            en    = 1'b1;
            din_r = W'(base_r + k);
            din_i = W'(base_i + k);
            tick;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || vld_out) && n < budget) begin
            tick;
            n++;
        end
        check("drained", {vld_out, 32'(exp_q.size())}, 64'd0);
    endtask

    initial begin
        int caps;
        int budget;
        int idx;

        #1 rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;

        // Basic reorder and first-output latency
        log_n = 0;
        feed(0, 100, 1'b0);
        en = 1'b0;
        check("latency_pre", vld_out, 1'b0);
        tick;
        check("latency_first", {vld_out, sop, dout_r}, {1'b1, 1'b1, 20'd0});
        wait_idle(50);
        check("t1_count", log_n, 8);
        for (int k = 0; k < NS; k++) begin
            check("t1_word", {acc_log[k].r, acc_log[k].i}, {20'(k), 20'(k + 100)});
        end
        check("t1_markers", {acc_log[0].sop, acc_log[7].eop, acc_log[3].sop, acc_log[3].eop},
              4'b1100);

        // Back-to-back frames
        log_n = 0;
        feed(0, 100, 1'b1);
        feed(8, 108, 1'b1);
        en = 1'b0;
        wait_idle(60);
        check("t2_count", log_n, 16);
        check("t2_no_bubble", acc_cyc[15] - acc_cyc[0], 15);
        for (int k = 0; k < 16; k++) begin
            check("t2_word", {acc_log[k].sop, acc_log[k].eop, acc_log[k].r},
                  {k % 8 == 0, k % 8 == 7, 20'(k)});
        end

        // Backpressure
        log_n     = 0;
        out_ready = 1'b0;
        feed(0, 100, 1'b0);
        feed(0, 200, 1'b0);
        check("t3_in_ready_low", in_ready, 1'b0);
        din_r = 20'd99;
        din_i = 20'd99;
        tick;
        en = 1'b0;
        check("t3_overflow", overflow, 1'b1);
        repeat (3) tick;
        check("t3_held", {vld_out, sop, dout_r, dout_i}, {1'b1, 1'b1, 20'd0, 20'd100});
        out_ready = 1'b1;
        wait_idle(60);
        check("t3_count", log_n, 16);
        for (int k = 0; k < 16; k++) begin
            check("t3_word", {acc_log[k].r, acc_log[k].i},
                  {20'(k % 8), 20'((k < 8 ? 100 : 200) + k % 8)});
        end

        // Reset mid-frame
        out_ready = 1'b0;
        feed(50, 60, 1'b0);
        for (int p = 0; p < 5; p++) begin
            din_r = W'(70 + p);
            din_i = W'(80 + p);
            tick;
        end
        en = 1'b0;
        check("t4_vld_before_rst", vld_out, 1'b1);
        rst = 1'b1;
        #1;
        check("t4_async_clear", {vld_out, sop, eop, overflow, dout_r, dout_i}, 64'd0);
        tick;
        rst = 1'b0;
        tick;
        out_ready = 1'b1;
        log_n     = 0;
        feed(200, 300, 1'b0);
        en = 1'b0;
        wait_idle(50);
        check("t4_count", log_n, 8);
        for (int k = 0; k < NS; k++) begin
            check("t4_word", {acc_log[k].sop, acc_log[k].r, acc_log[k].i},
                  {k == 0, 20'(200 + k), 20'(300 + k)});
        end

        // Random stalls, 50 frames
        caps   = 0;
        budget = 0;
        log_n  = 0;
        while (caps < 50 * NS && budget < 20000) begin
            din_r     = W'($urandom);
            din_i     = W'($urandom);
            en        = ($urandom_range(0, 9) < 7) && in_ready;
            out_ready = ($urandom_range(0, 9) < 6);
            if (en) caps++;
            tick;
            budget++;
        end
        en        = 1'b0;
        out_ready = 1'b1;
        check("t5_captures", caps, 50 * NS);
        wait_idle(100);
        check("t5_count", log_n, 50 * NS);
        check("t5_overflow", overflow, 1'b0);

        // N=256 butterfly-format frame
        for (int p = 0; p < NL; p++) begin
            int k;
            k      = bitrev_tb(p, 8);
            en_l   = 1'b1;
            din_lr = W'(k << 9);
            din_li = W'((255 - k) << 9);
            tick;
        end
        en_l   = 1'b0;
        idx    = 0;
        budget = 0;
        while (idx < NL && budget < 1000) begin
            if (vld_l) begin
                check("t6_word", {sop_l, eop_l, dout_lr, dout_li},
                      {idx == 0, idx == NL - 1, W'(idx << 9), W'((255 - idx) << 9)});
                idx++;
            end
            tick;
            budget++;
        end
        check("t6_count", idx, NL);
        check("t6_overflow", ovf_l, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
